// File: rtl/hsv_core_issue_scoreboard.sv
// hsv_core_issue_scoreboard: per-register pending-write counters that
// gate issue->exec dispatch on RAW hazards and rd counter saturation.
module hsv_core_issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk_core,
  input  logic                rst_core_n,
  input  logic                flush_req,
  output logic                flush_ack,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [4:0]          in_rd,
  input  logic                in_rs1_used,
  input  logic                in_rs2_used,
  input  logic                in_rd_used,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v;
  logic [NUM_REGS-1:0] dec_v;
  logic                flush_ack_q;
  logic                haz_rs1;
  logic                haz_rs2;
  logic                haz_rd;
  logic                haz;
  logic                fire;

  // Hazards look only at registered counts; a same-cycle wb does not bypass.
  assign haz_rs1 = in_rs1_used & (in_rs1 != '0)
                 & (cnt_q[in_rs1] != '0);
  assign haz_rs2 = in_rs2_used & (in_rs2 != '0)
                 & (cnt_q[in_rs2] != '0);
  assign haz_rd  = in_rd_used & (in_rd != '0)
                 & (cnt_q[in_rd] == CntMax);
  assign haz     = haz_rs1 | haz_rs2 | haz_rd;

  assign out_valid = in_valid & ~haz & ~flush_req;
  assign in_ready  = out_ready & ~haz & ~flush_req;
  assign fire      = out_valid & out_ready;
  assign flush_ack = flush_ack_q;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (fire && in_rd_used && in_rd != '0)
      inc_v[in_rd] = 1'b1;
    if (wb_valid && wb_rd != '0 && cnt_q[wb_rd] != '0)
      dec_v[wb_rd] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_req)
        cnt_d[i] = '0;
      else if (inc_v[i] && !dec_v[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_v[i] && !inc_v[i])
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++)
      busy_vec[i] = (cnt_q[i] != '0);
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      flush_ack_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= '0;
    end else begin
      flush_ack_q <= flush_req;
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  // Retiring a register with nothing in flight means writeback lost sync.
  retire_nonzero: assert property (
    @(posedge clk_core) disable iff (!rst_core_n)
    (wb_valid && !flush_req && wb_rd != '0)
      |-> (cnt_q[wb_rd] != '0)
  );

endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// tb_hsv_core_issue_scoreboard: directed vectors, expectations queued
// per cycle and checked by an independent negedge monitor.
module tb_hsv_core_issue_scoreboard;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        flush_req;
  logic        flush_ack;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rs1_used;
  logic        in_rs2_used;
  logic        in_rd_used;
  logic        out_valid;
  logic        out_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy_vec;

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [31:0] busy;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];
  int   vid_q[$];
  int   vid    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_issue_scoreboard #(
    .NUM_REGS (32),
    .CNT_W    (2)
  ) dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_rs1_used (in_rs1_used),
    .in_rs2_used (in_rs2_used),
    .in_rd_used  (in_rd_used),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .busy_vec    (busy_vec)
  );

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_rs1      = '0;
    in_rs2      = '0;
    in_rd       = '0;
    in_rs1_used = 1'b0;
    in_rs2_used = 1'b0;
    in_rd_used  = 1'b0;
    out_ready   = 1'b1;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    flush_req   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
    idle_inputs();
  endtask

  task automatic op(
    input logic       v,
    input logic [4:0] rs1,
    input logic       u1,
    input logic [4:0] rs2,
    input logic       u2,
    input logic [4:0] rd,
    input logic       ud
  );
    in_valid    = v;
    in_rs1      = rs1;
    in_rs1_used = u1;
    in_rs2      = rs2;
    in_rs2_used = u2;
    in_rd       = rd;
    in_rd_used  = ud;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
  endtask

  task automatic push(
    input logic        ov,
    input logic        ir,
    input logic [31:0] busy,
    input logic        ack
  );
    exp_t e;
    e.ov   = ov;
    e.ir   = ir;
    e.busy = busy;
    e.ack  = ack;
    exp_q.push_back(e);
    vid_q.push_back(vid);
    vid++;
  endtask

  task automatic cmp(
    input string       nm,
    input int          id,
    input logic [31:0] act,
    input logic [31:0] want
  );
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h want %h",
               nm, id, act, want);
    end
  endtask

  always @(negedge clk_core) begin
    exp_t e;
    int   id;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      id = vid_q.pop_front();
      cmp("out_valid", id, {31'd0, out_valid}, {31'd0, e.ov});
      cmp("in_ready",  id, {31'd0, in_ready},  {31'd0, e.ir});
      cmp("busy_vec",  id, busy_vec,           e.busy);
      cmp("flush_ack", id, {31'd0, flush_ack}, {31'd0, e.ack});
    end
  end

  initial begin
    rst_core_n = 1'b0;
    idle_inputs();

    // reset state
    tick(); rst_core_n = 1'b0; push(0, 1, 0, 0);
    tick(); rst_core_n = 1'b1; push(0, 1, 0, 0);

    // RAW on x5, released the cycle after wb
    tick(); op(1, 0, 0, 0, 0, 5, 1); push(1, 1, 0, 0);
    tick(); op(1, 5, 1, 0, 0, 0, 0); push(0, 0, b(5), 0);
    tick(); op(1, 5, 1, 0, 0, 0, 0); wb(5);
    push(0, 0, b(5), 0);
    tick(); op(1, 5, 1, 0, 0, 0, 0); push(1, 1, 0, 0);

    // x7 saturation
    tick(); op(1, 0, 0, 0, 0, 7, 1); push(1, 1, 0, 0);
    tick(); op(1, 0, 0, 0, 0, 7, 1); push(1, 1, b(7), 0);
    tick(); op(1, 0, 0, 0, 0, 7, 1); push(1, 1, b(7), 0);
    tick(); op(1, 0, 0, 0, 0, 7, 1); push(0, 0, b(7), 0);
    tick(); op(1, 8, 1, 0, 0, 0, 0); push(1, 1, b(7), 0);
    tick(); op(1, 0, 0, 0, 0, 7, 1); wb(7);
    push(0, 0, b(7), 0);
    tick(); op(1, 0, 0, 0, 0, 7, 1); push(1, 1, b(7), 0);

    // rs2 hazard on saturated x7
    tick(); op(1, 0, 0, 7, 1, 0, 0); push(0, 0, b(7), 0);

    // same-cycle fire and retire on x3
    tick(); op(1, 0, 0, 0, 0, 3, 1); push(1, 1, b(7), 0);
    tick(); op(1, 0, 0, 0, 0, 3, 1); wb(3);
    push(1, 1, b(7) | b(3), 0);
    tick(); push(0, 1, b(7) | b(3), 0);

    // x0 never tracked
    tick(); op(1, 0, 1, 0, 1, 0, 1); wb(0);
    push(1, 1, b(7) | b(3), 0);
    tick(); op(1, 0, 1, 0, 1, 0, 1); wb(0);
    push(1, 1, b(7) | b(3), 0);

    // exec back-pressure: no fire, no count
    tick(); op(1, 0, 0, 0, 0, 2, 1); out_ready = 1'b0;
    push(1, 0, b(7) | b(3), 0);
    tick(); op(1, 2, 1, 0, 0, 0, 0);
    push(1, 1, b(7) | b(3), 0);

    // flush with x1=2, x9=1 and wb ignored
    tick(); op(1, 0, 0, 0, 0, 1, 1); push(1, 1, b(7) | b(3), 0);
    tick(); op(1, 0, 0, 0, 0, 1, 1);
    push(1, 1, b(7) | b(3) | b(1), 0);
    tick(); op(1, 0, 0, 0, 0, 9, 1);
    push(1, 1, b(7) | b(3) | b(1), 0);
    tick(); op(1, 0, 0, 0, 0, 0, 0); wb(1); flush_req = 1'b1;
    push(0, 0, b(7) | b(3) | b(1) | b(9), 0);
    tick(); push(0, 1, 0, 1);
    tick(); op(1, 1, 1, 0, 0, 0, 0); push(1, 1, 0, 0);

    // async reset mid-stream with x4=2
    tick(); op(1, 0, 0, 0, 0, 4, 1); push(1, 1, 0, 0);
    tick(); op(1, 0, 0, 0, 0, 4, 1); push(1, 1, b(4), 0);
    tick(); op(1, 0, 0, 0, 0, 0, 0); push(1, 1, b(4), 0);
    tick(); op(1, 0, 0, 0, 0, 0, 0); rst_core_n = 1'b0;
    push(1, 1, 0, 0);
    tick(); rst_core_n = 1'b1; op(1, 4, 1, 0, 0, 0, 0);
    push(1, 1, 0, 0);

    // held flush: ack tracks flush_req one cycle late
    tick(); flush_req = 1'b1; op(1, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0);
    tick(); flush_req = 1'b1; push(0, 0, 0, 1);
    tick(); push(0, 1, 0, 1);
    tick(); push(0, 1, 0, 0);

    tick();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      @(posedge clk_core);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
